// File: rtl/io_output_bank.sv
// Bank of NUM_CH memory-mapped 32-bit output registers with byte-lane WRITE/SET/CLR/TGL ops and optional shadow/commit.
// Latency: store effects are visible one cycle after the store edge; load data returns one cycle after the load strobe.
// Backpressure: none; every store and load strobe is accepted in the cycle it is presented.
module io_output_bank #(
    parameter int          NUM_CH    = 5,
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int          SHADOW_EN = 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_io_wren,
    input  logic                  i_io_rden,
    input  logic [31:0]           i_io_addr,
    input  logic [31:0]           i_st_data,
    input  logic [2:0]            i_funct3,
    output logic [NUM_CH*32-1:0]  o_io_out,
    output logic [31:0]           o_io_rdata,
    output logic                  o_io_rvalid,
    output logic                  o_err_misalign,
    output logic [7:0]            o_err_count
);

    // Base is 4 KiB aligned, so page arithmetic only needs the upper 20 bits.
    localparam logic [19:0] BASE_PAGE = BASE_ADDR[31:12];

    logic [31:0] out_q [NUM_CH];
    logic [31:0] shd_q [NUM_CH];

    logic [19:0] rel_page;
    logic        above_base;
    logic        ch_hit;
    logic        cm_hit;
    logic [3:0]  ch_idx;
    logic        op_region;
    logic        shd_region;

    logic        size_bad;
    logic [31:0] lane_mask;
    logic [31:0] lane_data;
    logic [31:0] st_dat;

    logic        st_vld;
    logic        cm_vld;
    logic        rej_vld;

    logic [31:0] cur_val;
    logic [31:0] new_val;
    logic [31:0] rd_dat;

    // Page decode relative to the bank base.
    assign above_base = (i_io_addr[31:12] >= BASE_PAGE);
    assign rel_page   = i_io_addr[31:12] - BASE_PAGE;
    assign ch_hit     = above_base && (rel_page < 20'(NUM_CH));
    assign cm_hit     = above_base && (rel_page == 20'(NUM_CH));
    assign ch_idx     = rel_page[3:0];
    assign op_region  = (i_io_addr[11:4] == 8'h00);
    assign shd_region = (i_io_addr[11:2] == 10'h004);

    // Access-size legality, byte-lane mask and lane-replicated store data.
    always_comb begin
        size_bad  = 1'b0;
        lane_mask = 32'hFFFF_FFFF;
        lane_data = i_st_data;
        case (i_funct3)
            3'b000: begin
                lane_mask = 32'h0000_00FF << {i_io_addr[1:0], 3'b000};
                lane_data = {4{i_st_data[7:0]}};
            end
            3'b001: begin
                lane_mask = 32'h0000_FFFF << {i_io_addr[1], 4'b0000};
                lane_data = {2{i_st_data[15:0]}};
                size_bad  = i_io_addr[0];
            end
            3'b010:  size_bad = (i_io_addr[1:0] != 2'b00);
            default: size_bad = 1'b1;
        endcase
    end

    assign st_dat = lane_data & lane_mask;

    // Rejection applies to any page hit; a legal store then acts only in the op window or as a commit.
    assign rej_vld = i_io_wren && (ch_hit || cm_hit) && size_bad;
    assign st_vld  = i_io_wren && ch_hit && !size_bad && op_region;
    assign cm_vld  = (SHADOW_EN != 0) && i_io_wren && cm_hit && !size_bad
                     && (i_funct3 == 3'b010) && (i_io_addr[11:2] == 10'h000);

    // Select the register that the store targets (shadow when shadowing is enabled).
    always_comb begin
        cur_val = 32'h0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_idx == 4'(i)) begin
                cur_val = (SHADOW_EN != 0) ? shd_q[i] : out_q[i];
            end
        end
    end

    // Apply the op selected by address bits [3:2].
    always_comb begin
        new_val = cur_val;
        case (i_io_addr[3:2])
            2'b00: new_val = (cur_val & ~lane_mask) | st_dat;
            2'b01: new_val = cur_val | st_dat;
            2'b10: new_val = cur_val & ~st_dat;
            2'b11: new_val = cur_val ^ st_dat;
            default: new_val = cur_val;
        endcase
    end

    // Load mux: live output in the op window, shadow in the readback word, zero elsewhere.
    always_comb begin
        rd_dat = 32'h0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_hit && (ch_idx == 4'(i))) begin
                if (op_region) begin
                    rd_dat = out_q[i];
                end else if (shd_region) begin
                    rd_dat = shd_q[i];
                end
            end
        end
    end

    // Data registers: per-channel store update and same-edge multi-channel commit.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                out_q[i] <= 32'h0;
                shd_q[i] <= 32'h0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (cm_vld && i_st_data[i]) begin
                    out_q[i] <= shd_q[i];
                end
                if (st_vld && (ch_idx == 4'(i))) begin
                    if (SHADOW_EN != 0) begin
                        shd_q[i] <= new_val;
                    end else begin
                        out_q[i] <= new_val;
                    end
                end
            end
        end
    end

    // Registered load response; samples pre-store register values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_io_rvalid <= 1'b0;
            o_io_rdata  <= 32'h0;
        end else begin
            o_io_rvalid <= i_io_rden;
            o_io_rdata  <= i_io_rden ? rd_dat : 32'h0;
        end
    end

    // Sticky error flag and saturating reject counter.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_err_misalign <= 1'b0;
            o_err_count    <= 8'h00;
        end else if (rej_vld) begin
            o_err_misalign <= 1'b1;
            if (o_err_count != 8'hFF) begin
                o_err_count <= o_err_count + 8'h01;
            end
        end
    end

    // Flatten the output registers onto the output bus.
    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_out
            assign o_io_out[32*g +: 32] = out_q[g];
        end
    endgenerate

endmodule

// File: tb/tb_io_output_bank.sv
// Bench for io_output_bank: a direct-output instance and a shadowed instance share one stimulus stream.
// Latency: each step drives on the falling edge and samples 1 time unit after the next rising edge.
// Backpressure: not applicable; the DUT accepts every strobe.
module tb_io_output_bank;

    localparam int          NUM_CH = 5;
    localparam logic [31:0] BASE   = 32'h1000_0000;

    logic                 i_clk = 1'b0;
    logic                 i_reset = 1'b1;
    logic                 i_io_wren = 1'b0;
    logic                 i_io_rden = 1'b0;
    logic [31:0]          i_io_addr = 32'h0;
    logic [31:0]          i_st_data = 32'h0;
    logic [2:0]           i_funct3 = 3'b000;

    logic [NUM_CH*32-1:0] out0, out1;
    logic [31:0]          rdata0, rdata1;
    logic                 rvalid0, rvalid1;
    logic                 err0, err1;
    logic [7:0]           cnt0, cnt1;

    always #5 i_clk = ~i_clk;

    io_output_bank #(.NUM_CH(NUM_CH), .BASE_ADDR(BASE), .SHADOW_EN(0)) dut0 (
        .i_clk(i_clk), .i_reset(i_reset), .i_io_wren(i_io_wren), .i_io_rden(i_io_rden),
        .i_io_addr(i_io_addr), .i_st_data(i_st_data), .i_funct3(i_funct3),
        .o_io_out(out0), .o_io_rdata(rdata0), .o_io_rvalid(rvalid0),
        .o_err_misalign(err0), .o_err_count(cnt0)
    );

    io_output_bank #(.NUM_CH(NUM_CH), .BASE_ADDR(BASE), .SHADOW_EN(1)) dut1 (
        .i_clk(i_clk), .i_reset(i_reset), .i_io_wren(i_io_wren), .i_io_rden(i_io_rden),
        .i_io_addr(i_io_addr), .i_st_data(i_st_data), .i_funct3(i_funct3),
        .o_io_out(out1), .o_io_rdata(rdata1), .o_io_rvalid(rvalid1),
        .o_err_misalign(err1), .o_err_count(cnt1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: dut0 outputs, dut1 outputs and shadows, shared error state.
    logic [31:0] m_out0 [NUM_CH];
    logic [31:0] m_out1 [NUM_CH];
    logic [31:0] m_shd1 [NUM_CH];
    logic        m_err;
    int          m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] size_mask(input logic [31:0] a, input logic [2:0] f);
        case (f)
            3'd0:    return 32'hFF << (8 * (a % 4));
            3'd1:    return 32'hFFFF << (16 * ((a / 2) % 2));
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [31:0] replicate(input logic [31:0] d, input logic [2:0] f);
        case (f)
            3'd0:    return (d & 32'hFF) * 32'h0101_0101;
            3'd1:    return (d & 32'hFFFF) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic bit legal(input logic [31:0] a, input logic [2:0] f);
        return (f == 3'd0) || (f == 3'd1 && (a % 2) == 0) || (f == 3'd2 && (a % 4) == 0);
    endfunction

    function automatic logic [31:0] apply_op(input logic [31:0] r, input int op,
                                             input logic [31:0] mask, input logic [31:0] d);
        case (op)
            0:       return (r & ~mask) | d;
            1:       return r | d;
            2:       return r & ~d;
            default: return r ^ d;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input bit shadowed);
        int          pg;
        int          off;
        if (a < BASE) return 32'h0;
        pg  = int'((a - BASE) / 4096);
        off = int'(a % 4096);
        if (pg >= NUM_CH) return 32'h0;
        if (off < 16) return shadowed ? m_out1[pg] : m_out0[pg];
        if (off < 20) return shadowed ? m_shd1[pg] : 32'h0;
        return 32'h0;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        int          pg;
        int          off;
        logic [31:0] mask;
        logic [31:0] dd;
        if (a < BASE) return;
        pg = int'((a - BASE) / 4096);
        if (pg > NUM_CH) return;
        if (!legal(a, f)) begin
            m_err = 1'b1;
            if (m_cnt < 255) m_cnt++;
            return;
        end
        off = int'(a % 4096);
        if (pg == NUM_CH) begin
            if (f == 3'd2 && off == 0) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (d[i]) m_out1[i] = m_shd1[i];
                end
            end
            return;
        end
        if (off >= 16) return;
        mask = size_mask(a, f);
        dd   = replicate(d, f) & mask;
        m_out0[pg] = apply_op(m_out0[pg], off / 4, mask, dd);
        m_shd1[pg] = apply_op(m_shd1[pg], off / 4, mask, dd);
    endtask

    task automatic step(input bit rst, input bit wr, input bit rd, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] f);
        bit          exp_rv;
        logic [31:0] exp_r0;
        logic [31:0] exp_r1;
        @(negedge i_clk);
        i_reset   = rst;
        i_io_wren = wr;
        i_io_rden = rd;
        i_io_addr = a;
        i_st_data = d;
        i_funct3  = f;
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_out0[i] = 32'h0;
                m_out1[i] = 32'h0;
                m_shd1[i] = 32'h0;
            end
            m_err  = 1'b0;
            m_cnt  = 0;
            exp_rv = 1'b0;
            exp_r0 = 32'h0;
            exp_r1 = 32'h0;
        end else begin
            exp_rv = rd;
            exp_r0 = rd ? model_load(a, 1'b0) : 32'h0;
            exp_r1 = rd ? model_load(a, 1'b1) : 32'h0;
            if (wr) model_store(a, d, f);
        end
        @(posedge i_clk);
        #1;
        check("rvalid0", {31'h0, rvalid0}, {31'h0, exp_rv});
        check("rvalid1", {31'h0, rvalid1}, {31'h0, exp_rv});
        if (exp_rv || rst) begin
            check("rdata0", rdata0, exp_r0);
            check("rdata1", rdata1, exp_r1);
        end
        for (int i = 0; i < NUM_CH; i++) begin
            check($sformatf("out0[%0d]", i), out0[32*i +: 32], m_out0[i]);
            check($sformatf("out1[%0d]", i), out1[32*i +: 32], m_out1[i]);
        end
        check("err0", {31'h0, err0}, {31'h0, m_err});
        check("err1", {31'h0, err1}, {31'h0, m_err});
        check("cnt0", {24'h0, cnt0}, 32'(m_cnt));
        check("cnt1", {24'h0, cnt1}, 32'(m_cnt));
        i_io_wren = 1'b0;
        i_io_rden = 1'b0;
        i_reset   = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  f;
        int          off;

        // Reset with a coinciding store that must be discarded.
        step(1, 1, 1, BASE, 32'hFFFF_FFFF, 3'd2);
        check("reset_out0", out0[31:0], 32'h0);
        check("reset_cnt", {24'h0, cnt0}, 32'h0);

        // Word write then byte overwrite of lane 2 on the direct instance.
        step(0, 1, 0, 32'h1000_0000, 32'h1234_5678, 3'd2);
        step(0, 1, 0, 32'h1000_0002, 32'h0000_00AB, 3'd0);
        check("byte_merge", out0[31:0], 32'h12AB_5678);

        // SET / CLR / TGL sequence on channel 1.
        step(0, 1, 0, 32'h1000_1000, 32'h0000_00F0, 3'd2);
        step(0, 1, 0, 32'h1000_1004, 32'h0000_000F, 3'd2);
        check("set_op", out0[63:32], 32'h0000_00FF);
        step(0, 1, 0, 32'h1000_1008, 32'h0000_0030, 3'd2);
        check("clr_op", out0[63:32], 32'h0000_00CF);
        step(0, 1, 0, 32'h1000_100C, 32'h0000_00FF, 3'd2);
        check("tgl_op", out0[63:32], 32'h0000_0030);

        // Shadowed instance: stores hold in shadow until a commit selects channel 2 only.
        step(0, 1, 0, 32'h1000_2000, 32'hDEAD_BEEF, 3'd2);
        step(0, 1, 0, 32'h1000_3000, 32'h0000_0001, 3'd2);
        check("shadow_hold2", out1[95:64], 32'h0);
        step(0, 1, 0, 32'h1000_5000, 32'h0000_0004, 3'd2);
        check("commit_ch2", out1[95:64], 32'hDEAD_BEEF);
        check("commit_ch3", out1[127:96], 32'h0);
        step(0, 0, 1, 32'h1000_3010, 32'h0, 3'd2);
        check("shadow_readback", rdata1, 32'h0000_0001);

        // Rejected stores: misaligned half and illegal size, then saturation.
        step(0, 1, 0, 32'h1000_0001, 32'h0000_FFFF, 3'd1);
        step(0, 1, 0, 32'h1000_0000, 32'hFFFF_FFFF, 3'd3);
        check("err_flag", {31'h0, err0}, 32'h1);
        check("err_cnt2", {24'h0, cnt0}, 32'h2);
        for (int k = 0; k < 300; k++) step(0, 1, 0, 32'h1000_0000, 32'hFFFF_FFFF, 3'd3);
        check("err_sat", {24'h0, cnt0}, 32'hFF);

        // Load concurrent with store returns the pre-store value; out-of-range load returns 0.
        step(0, 1, 1, 32'h1000_0000, 32'h0000_0055, 3'd2);
        check("load_old", rdata0, 32'h12AB_5678);
        step(0, 0, 1, 32'h1000_7000, 32'h0, 3'd2);
        check("load_miss", rdata0, 32'h0);

        // Randomized traffic against the reference model.
        step(1, 0, 0, 32'h0, 32'h0, 3'd0);
        for (int k = 0; k < 1500; k++) begin
            case ($urandom_range(0, 5))
                0, 1, 2, 3: off = $urandom_range(0, 15);
                4:          off = 16 + $urandom_range(0, 3);
                default:    off = $urandom_range(0, 4095);
            endcase
            f = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
            if ($urandom_range(0, 3) != 0) begin
                if (f == 3'd1) off = off & ~1;
                if (f == 3'd2) off = off & ~3;
            end
            a = BASE + 32'($urandom_range(0, 7)) * 32'h1000 + 32'(off);
            if ($urandom_range(0, 19) == 0) a = $urandom();
            if ($urandom_range(0, 29) == 0) a = BASE - 32'd4;
            step($urandom_range(0, 199) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 a, $urandom(), f);
        end

        // Reset after traffic clears everything.
        step(0, 1, 0, 32'h1000_0001, 32'h0, 3'd2);
        step(1, 0, 0, 32'h0, 32'h0, 3'd0);
        check("final_out0", out0[31:0], 32'h0);
        check("final_out1", out1[95:64], 32'h0);
        check("final_err", {31'h0, err1}, 32'h0);
        check("final_cnt", {24'h0, cnt1}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/io_output_bank.md
IO_OUTPUT_BANK -- requirements
Module: io_output_bank

Interface
REQ-001 Parameter NUM_CH, default 5, number of 32-bit output channels, legal range 1..16.
REQ-002 Parameter BASE_ADDR, default 32'h1000_0000, base address of channel 0; must be 4 KiB aligned.
REQ-003 Parameter SHADOW_EN, default 1; 1 = stores target shadow registers and a commit is required, 0 = stores update outputs directly.
REQ-004 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 i_reset  input  1  reset, synchronous, active-high.
REQ-006 i_io_wren  input  1  store strobe, one store per asserted cycle.
REQ-007 i_io_rden  input  1  load strobe, one load per asserted cycle.
REQ-008 i_io_addr  input  32  byte address of the access.
REQ-009 i_st_data  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 i_funct3  input  3  access size: 000 byte, 001 half, 010 word; other codes illegal.
REQ-011 o_io_out  output  NUM_CH*32  flattened output registers, channel i at [32*i+31:32*i].
REQ-012 o_io_rdata  output  32  load data.
REQ-013 o_io_rvalid  output  1  o_io_rdata is valid this cycle.
REQ-014 o_err_misalign  output  1  sticky flag for illegal or misaligned stores.
REQ-015 o_err_count  output  8  saturating count of rejected stores.

Function
REQ-016 Decode: channel page i = (addr - BASE_ADDR) >> 12; hit only when addr >= BASE_ADDR and i < NUM_CH; the commit page is i == NUM_CH; all other addresses are ignored with no state change and no error.
REQ-017 Page offset addr[11:4] == 0 selects op by addr[3:2]: 00 WRITE, 01 SET, 10 CLR, 11 TGL; offset 0x010-0x013 is shadow readback (read-only); other offsets are ignored.
REQ-018 Byte lanes: SB mask = 0xFF << 8*addr[1:0]; SH mask = 0xFFFF << 16*addr[1]; SW mask = all ones; data is replicated into the selected lanes (d = aligned data & mask).
REQ-019 Ops on target register R: WRITE R = (R & ~mask) | d; SET R = R | d; CLR R = R & ~d; TGL R = R ^ d.
REQ-020 Target register R is shadow[i] when SHADOW_EN=1 and out[i] when SHADOW_EN=0; the update is visible on the cycle after the store edge.
REQ-021 Commit (SHADOW_EN=1): SW to the commit page at offset 0 copies shadow[i] to out[i] for every i where i_st_data[i] = 1, all in the same edge; shadows are unchanged; data bits >= NUM_CH are ignored.
REQ-022 Commit with SB/SH, or any commit-page store when SHADOW_EN=0, is ignored without error.
REQ-023 A store is rejected when it has a channel or commit-page hit and any of these holds: funct3 is illegal, SH has addr[0]=1, or SW has addr[1:0]!=0.
REQ-024 A rejected store changes no data register, sets o_err_misalign, and increments o_err_count, which saturates at 8'hFF.
REQ-025 Load: when i_io_rden is high on a hit, o_io_rvalid = 1 and o_io_rdata = full 32-bit out[i] (offset 0x000-0x00F) or shadow[i] (0x010-0x013), registered with 1-cycle latency.
REQ-026 A load that misses the decode, or any commit-page load, returns o_io_rvalid = 1 and o_io_rdata = 0; o_io_rvalid = 0 when i_io_rden = 0.
REQ-027 A load and a store in the same cycle are both performed; the load returns the pre-store value.
REQ-028 o_err_misalign clears only on reset.

Reset
REQ-029 While i_reset is high at a clock edge: all out and shadow registers are set to 0, o_io_rdata = 0, o_io_rvalid = 0, o_err_misalign = 0, o_err_count = 0.
REQ-030 A store or load coinciding with i_reset is discarded.
REQ-031 Reset takes priority over every other operation.

Verification
REQ-032 SHADOW_EN=0: SW 0x1000_0000 = 0x1234_5678, then SB 0x1000_0002 = 0xAB -> out[0] = 0x12AB_5678.
REQ-033 SHADOW_EN=0, out[1] = 0x0000_00F0: SET 0x1000_1004 = 0x0F, then CLR 0x1000_1008 = 0x30, then TGL 0x1000_100C = 0xFF -> out[1] values are 0xFF, then 0xCF, then 0x30.
REQ-034 SHADOW_EN=1: SW shadow[2] = 0xDEAD_BEEF and shadow[3] = 0x1 -> o_io_out unchanged; then SW 0x1000_5000 = 0x4 -> only out[2] = 0xDEAD_BEEF, and out[3] is still 0.
REQ-035 SH 0x1000_0001 followed by funct3 = 011 to 0x1000_0000 -> no register change, o_err_misalign = 1, o_err_count = 2; after 300 more such stores, o_err_count = 0xFF.
REQ-036 Load 0x1000_0000 in the same cycle as SW = 0x55 -> next cycle o_io_rvalid = 1 and o_io_rdata = the old value; load 0x1000_7000 -> o_io_rdata = 0.
REQ-037 Assert i_reset for 1 cycle after arbitrary traffic -> on the next cycle all outputs and counters are 0.
